// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic PE row: FSM encoding and default sizing.
package systolic_pkg;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_ACC_W       = 24;
  localparam int DEF_NUM_PE      = 4;
  localparam int DEF_SIGNED_MODE = 1;
  localparam int K_LEN_W         = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/systolic_pe.sv
// One processing element: forwards left/up operands a cycle later and runs a
// saturating multiply-accumulate bounded by the job's MAC count.
module systolic_pe
  import systolic_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int SIGNED_MODE = DEF_SIGNED_MODE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               compute_i,
  input  logic [K_LEN_W-1:0] k_len_i,
  input  logic [DATA_W-1:0]  left_data_i,
  input  logic               left_valid_i,
  input  logic [DATA_W-1:0]  up_data_i,
  input  logic               up_valid_i,
  output logic [DATA_W-1:0]  left_data_o,
  output logic               left_valid_o,
  output logic [DATA_W-1:0]  down_data_o,
  output logic               down_valid_o,
  output logic [ACC_W-1:0]   acc_o,
  output logic               cnt_done_o,
  output logic               sat_o
);

  localparam int PW = 2 * DATA_W;
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] UMAX = {ACC_W{1'b1}};

  logic [DATA_W-1:0]  left_q, down_q;
  logic               left_valid_q, down_valid_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [K_LEN_W-1:0] cnt_q, cnt_d;
  logic               sat_q, sat_d;

  logic [PW-1:0]    a_ext, b_ext, prod;
  logic [ACC_W-1:0] prod_ext, clamp;
  logic [ACC_W:0]   sum;
  logic             ovf, mac_en;

  always_comb begin
    if (SIGNED_MODE != 0) begin
      a_ext    = {{DATA_W{left_q[DATA_W-1]}}, left_q};
      b_ext    = {{DATA_W{up_data_i[DATA_W-1]}}, up_data_i};
      prod     = a_ext * b_ext;
      prod_ext = ACC_W'($signed(prod));
    end else begin
      a_ext    = {{DATA_W{1'b0}}, left_q};
      b_ext    = {{DATA_W{1'b0}}, up_data_i};
      prod     = a_ext * b_ext;
      prod_ext = ACC_W'(prod);
    end
    sum = {1'b0, acc_q} + {1'b0, prod_ext};
    // Signed overflow: both addends share a sign that the sum does not.
    if (SIGNED_MODE != 0) begin
      ovf   = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
      clamp = acc_q[ACC_W-1] ? SMIN : SMAX;
    end else begin
      ovf   = sum[ACC_W];
      clamp = UMAX;
    end
    mac_en = compute_i && left_valid_q && up_valid_i && (cnt_q < k_len_i);

    acc_d = acc_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (mac_en) begin
      cnt_d = cnt_q + K_LEN_W'(1);
      if (ovf) begin
        acc_d = clamp;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_q       <= '0;
      left_valid_q <= 1'b0;
      down_q       <= '0;
      down_valid_q <= 1'b0;
      acc_q        <= '0;
      cnt_q        <= '0;
      sat_q        <= 1'b0;
    end else begin
      left_q       <= left_data_i;
      left_valid_q <= left_valid_i;
      down_q       <= up_data_i;
      down_valid_q <= up_valid_i;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      sat_q        <= sat_d;
    end
  end

  assign left_data_o  = left_q;
  assign left_valid_o = left_valid_q;
  assign down_data_o  = down_q;
  assign down_valid_o = down_valid_q;
  assign acc_o        = acc_q;
  assign cnt_done_o   = (cnt_q == k_len_i);
  assign sat_o        = sat_q;

endmodule

// File: rtl/systolic_pe_row.sv
// Row of NUM_PE systolic MAC elements with a job FSM that drains the
// accumulators one at a time over a valid/ready result port.
module systolic_pe_row
  import systolic_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int NUM_PE      = DEF_NUM_PE,
  parameter int SIGNED_MODE = DEF_SIGNED_MODE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        in_left_data,
  input  logic                     in_left_valid,
  input  logic [NUM_PE*DATA_W-1:0] in_up_data,
  input  logic [NUM_PE-1:0]        in_up_valid,
  output logic [DATA_W-1:0]        out_right_data,
  output logic                     out_right_valid,
  output logic [NUM_PE*DATA_W-1:0] out_down_data,
  output logic [NUM_PE-1:0]        out_down_valid,
  input  logic                     start,
  input  logic [K_LEN_W-1:0]       k_len,
  output logic                     busy,
  output logic [ACC_W-1:0]         res_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     res_last,
  output logic                     sat,
  output logic                     done
);

  localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [K_LEN_W-1:0] k_len_q, k_len_d;
  logic               done_q, done_d;
  logic               clear;

  logic [DATA_W-1:0] left_chain  [NUM_PE+1];
  logic              lvalid_chain[NUM_PE+1];
  logic [ACC_W-1:0]  acc_w       [NUM_PE];
  logic [NUM_PE-1:0] cnt_done_w, sat_w;

  assign left_chain[0]   = in_left_data;
  assign lvalid_chain[0] = in_left_valid;

  generate
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
      systolic_pe #(
        .DATA_W      (DATA_W),
        .ACC_W       (ACC_W),
        .SIGNED_MODE (SIGNED_MODE)
      ) u_pe (
        .clk          (clk),
        .rst          (rst),
        .clear_i      (clear),
        .compute_i    (state_q == ST_COMPUTE),
        .k_len_i      (k_len_q),
        .left_data_i  (left_chain[gi]),
        .left_valid_i (lvalid_chain[gi]),
        .up_data_i    (in_up_data[gi*DATA_W +: DATA_W]),
        .up_valid_i   (in_up_valid[gi]),
        .left_data_o  (left_chain[gi+1]),
        .left_valid_o (lvalid_chain[gi+1]),
        .down_data_o  (out_down_data[gi*DATA_W +: DATA_W]),
        .down_valid_o (out_down_valid[gi]),
        .acc_o        (acc_w[gi]),
        .cnt_done_o   (cnt_done_w[gi]),
        .sat_o        (sat_w[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    k_len_d = k_len_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear   = 1'b1;
          k_len_d = k_len;
          idx_d   = '0;
          state_d = (k_len == '0) ? ST_DRAIN : ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        if (&cnt_done_w) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (res_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      k_len_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      k_len_q <= k_len_d;
      done_q  <= done_d;
    end
  end

  assign out_right_data  = left_chain[NUM_PE];
  assign out_right_valid = lvalid_chain[NUM_PE];
  assign busy            = (state_q != ST_IDLE);
  assign res_valid       = (state_q == ST_DRAIN);
  assign res_data        = res_valid ? acc_w[idx_q] : '0;
  assign res_last        = res_valid && (idx_q == LAST_IDX);
  assign sat             = |sat_w;
  assign done            = done_q;

endmodule

// File: tb/tb_systolic_pe_row.sv
// Directed bench for systolic_pe_row; a 16-bit-accumulator copy shares the
// stimulus to exercise saturation.
module tb_systolic_pe_row;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_left_data;
  logic        in_left_valid;
  logic [31:0] in_up_data;
  logic [3:0]  in_up_valid;
  logic        start;
  logic [15:0] k_len;
  logic        res_ready;

  logic [7:0]  out_right_data;
  logic        out_right_valid;
  logic [31:0] out_down_data;
  logic [3:0]  out_down_valid;
  logic        busy, res_valid, res_last, sat, done;
  logic [23:0] res_data;

  logic [7:0]  d16_right_data;
  logic        d16_right_valid;
  logic [31:0] d16_down_data;
  logic [3:0]  d16_down_valid;
  logic        d16_busy, d16_res_valid, d16_res_last, d16_sat, d16_done;
  logic [15:0] d16_res_data;

  int n_cmp = 0;
  int n_bad = 0;
  int lv[4];
  int uv[4][4];
  int got[4];
  int got16[4];
  logic lastg[4];
  logic done_n1, done_n2, drain_timeout;
  int stall_changes;

  always #5 clk = ~clk;

  systolic_pe_row dut (
    .clk(clk), .rst(rst),
    .in_left_data(in_left_data), .in_left_valid(in_left_valid),
    .in_up_data(in_up_data), .in_up_valid(in_up_valid),
    .out_right_data(out_right_data), .out_right_valid(out_right_valid),
    .out_down_data(out_down_data), .out_down_valid(out_down_valid),
    .start(start), .k_len(k_len), .busy(busy),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .res_last(res_last), .sat(sat), .done(done)
  );

  systolic_pe_row #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_left_data(in_left_data), .in_left_valid(in_left_valid),
    .in_up_data(in_up_data), .in_up_valid(in_up_valid),
    .out_right_data(d16_right_data), .out_right_valid(d16_right_valid),
    .out_down_data(d16_down_data), .out_down_valid(d16_down_valid),
    .start(start), .k_len(k_len), .busy(d16_busy),
    .res_data(d16_res_data), .res_valid(d16_res_valid), .res_ready(res_ready),
    .res_last(d16_res_last), .sat(d16_sat), .done(d16_done)
  );

  task automatic start_job(input int k);
    @(negedge clk);
    in_left_valid = 1'b0;
    in_up_valid   = '0;
    start = 1'b1;
    k_len = 16'(k);
    @(negedge clk);
    start = 1'b0;
  endtask

  // PE i sees left step j one cycle after it was injected plus i hops.
  task automatic feed(input int k);
    int j;
    for (int c = 0; c < k + 4; c++) begin
      in_left_valid = (c < k);
      in_left_data  = (c < k) ? 8'(lv[c]) : 8'd0;
      for (int i = 0; i < 4; i++) begin
        j = c - 1 - i;
        if (j >= 0 && j < k) begin
          in_up_valid[i]        = 1'b1;
          in_up_data[i*8 +: 8]  = 8'(uv[i][j]);
        end else begin
          in_up_valid[i]        = 1'b0;
          in_up_data[i*8 +: 8]  = 8'd0;
        end
      end
      @(negedge clk);
    end
    in_left_valid = 1'b0;
    in_up_valid   = '0;
  endtask

  task automatic drain(input int stall_at, input int stall_n);
    int n, waitc, stalls;
    logic [23:0] held;
    n = 0; waitc = 0; stalls = 0; held = '0;
    stall_changes = 0;
    drain_timeout = 1'b0;
    res_ready = 1'b0;
    while (n < 4 && waitc < 60) begin
      @(negedge clk);
      waitc++;
      if (res_valid) begin
        if (n == stall_at && stalls < stall_n) begin
          if (stalls == 0) held = res_data;
          else if (res_data !== held) stall_changes++;
          res_ready = 1'b0;
          stalls++;
        end else begin
          if (n == stall_at && stalls > 0 && res_data !== held) stall_changes++;
          got[n]   = int'(res_data);
          got16[n] = int'(d16_res_data);
          lastg[n] = res_last;
          $display("result %0d: data=%0d data16=%0d last=%0b", n, res_data, d16_res_data, res_last);
          res_ready = 1'b1;
          n++;
        end
      end else begin
        res_ready = 1'b0;
      end
    end
    drain_timeout = (n < 4);
    @(negedge clk);
    res_ready = 1'b0;
    done_n1 = done;
    @(negedge clk);
    done_n2 = done;
  endtask

  task automatic test_reset();
    if (busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL reset_ctrl: busy=%b res_valid=%b done=%b, required 0", busy, res_valid, done);
    end
    n_cmp++;
    if (sat !== 1'b0 || res_last !== 1'b0 || res_data !== 24'd0) begin
      n_bad++; $display("FAIL reset_res: sat=%b last=%b data=%0d, required 0", sat, res_last, res_data);
    end
    n_cmp++;
    if (out_right_valid !== 1'b0 || out_down_valid !== 4'd0 || out_right_data !== 8'd0 || out_down_data !== 32'd0) begin
      n_bad++; $display("FAIL reset_fwd: rv=%b dv=%h rd=%h dd=%h, required 0", out_right_valid, out_down_valid, out_right_data, out_down_data);
    end
    n_cmp++;
    $display("reset state checked");
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    in_left_data = 8'h5A; in_left_valid = 1'b1;
    in_up_data = 32'hA1B2C3D4; in_up_valid = 4'b1010;
    @(negedge clk);
    in_left_valid = 1'b0; in_up_valid = 4'b0000; in_up_data = '0; in_left_data = '0;
    n_cmp++;
    if (out_down_data !== 32'hA1B2C3D4 || out_down_valid !== 4'b1010) begin
      n_bad++; $display("FAIL fwd_down: data=%h valid=%b, required a1b2c3d4 1010", out_down_data, out_down_valid);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_right_valid !== 1'b0) begin
      n_bad++; $display("FAIL fwd_right_early: valid=%b after 3 edges, required 0", out_right_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_right_valid !== 1'b1 || out_right_data !== 8'h5A) begin
      n_bad++; $display("FAIL fwd_right: valid=%b data=%h, required 1 5a", out_right_valid, out_right_data);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL fwd_idle_busy: busy=%b, required 0", busy);
    end
    $display("forwarding checked");
  endtask

  task automatic test_basic();
    lv[0] = 3; lv[1] = -2;
    for (int i = 0; i < 4; i++) begin uv[i][0] = i + 1; uv[i][1] = i + 1; end
    start_job(2);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: busy=%b, required 1", busy); end
    feed(2);
    drain(-1, 0);
    n_cmp++;
    if (drain_timeout) begin n_bad++; $display("FAIL basic_timeout: results missing, required 4"); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== i + 1 || lastg[i] !== (i == 3)) begin
        n_bad++; $display("FAIL basic_res%0d: data=%0d last=%b, required %0d %b", i, got[i], lastg[i], i + 1, (i == 3));
      end
    end
    n_cmp++;
    if (done_n1 !== 1'b1 || done_n2 !== 1'b0) begin
      n_bad++; $display("FAIL basic_done: pulse=%b,%b, required 1,0", done_n1, done_n2);
    end
  endtask

  task automatic test_no_overflow();
    lv[0] = 127;
    for (int i = 0; i < 4; i++) uv[i][0] = 127;
    start_job(1);
    feed(1);
    drain(-1, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== 16129 || got16[i] !== 16129) begin
        n_bad++; $display("FAIL max_res%0d: data=%0d data16=%0d, required 16129", i, got[i], got16[i]);
      end
    end
    n_cmp++;
    if (sat !== 1'b0 || d16_sat !== 1'b0) begin
      n_bad++; $display("FAIL max_sat: sat=%b sat16=%b, required 0 0", sat, d16_sat);
    end
  endtask

  task automatic test_saturation();
    for (int j = 0; j < 3; j++) begin
      lv[j] = -128;
      for (int i = 0; i < 4; i++) uv[i][j] = -128;
    end
    start_job(3);
    feed(3);
    drain(-1, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got16[i] !== 32767 || got[i] !== 49152) begin
        n_bad++; $display("FAIL sat_res%0d: data16=%0d data=%0d, required 32767 49152", i, got16[i], got[i]);
      end
    end
    n_cmp++;
    if (d16_sat !== 1'b1 || sat !== 1'b0) begin
      n_bad++; $display("FAIL sat_flag: sat16=%b sat=%b, required 1 0", d16_sat, sat);
    end
  endtask

  task automatic test_stall();
    lv[0] = 1; lv[1] = 2;
    for (int i = 0; i < 4; i++) begin uv[i][0] = i + 1; uv[i][1] = i + 2; end
    start_job(2);
    n_cmp++;
    if (d16_sat !== 1'b0) begin n_bad++; $display("FAIL stall_satclr: sat16=%b, required 0", d16_sat); end
    feed(2);
    drain(1, 5);
    n_cmp++;
    if (stall_changes !== 0 || drain_timeout) begin
      n_bad++; $display("FAIL stall_hold: changes=%0d timeout=%b, required 0 0", stall_changes, drain_timeout);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== 3 * i + 5 || lastg[i] !== (i == 3)) begin
        n_bad++; $display("FAIL stall_res%0d: data=%0d last=%b, required %0d %b", i, got[i], lastg[i], 3 * i + 5, (i == 3));
      end
    end
    n_cmp++;
    if (done_n1 !== 1'b1 || done_n2 !== 1'b0) begin
      n_bad++; $display("FAIL stall_done: pulse=%b,%b, required 1,0", done_n1, done_n2);
    end
  endtask

  task automatic test_reset_mid();
    start_job(2);
    in_left_data = 8'd2; in_left_valid = 1'b1;
    @(negedge clk);
    in_left_valid = 1'b0;
    in_up_data = 32'h00000003; in_up_valid = 4'b0001;
    @(negedge clk);
    in_up_valid = '0; in_up_data = '0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_busy_before: busy=%b, required 1", busy); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || res_last !== 1'b0 || done !== 1'b0 || sat !== 1'b0 || res_data !== 24'd0) begin
      n_bad++; $display("FAIL rmid_ctrl: busy=%b rv=%b last=%b done=%b sat=%b data=%0d, required 0", busy, res_valid, res_last, done, sat, res_data);
    end
    n_cmp++;
    if (out_right_valid !== 1'b0 || out_down_valid !== 4'd0 || out_right_data !== 8'd0 || out_down_data !== 32'd0) begin
      n_bad++; $display("FAIL rmid_fwd: rv=%b dv=%b rd=%h dd=%h, required 0", out_right_valid, out_down_valid, out_right_data, out_down_data);
    end
    @(negedge clk);
    rst = 1'b1;
    start = 1'b1;
    k_len = 16'd1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL rmid_first_start: busy=%b, required 1", busy); end
    lv[0] = 2;
    for (int i = 0; i < 4; i++) uv[i][0] = 3;
    feed(1);
    drain(-1, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== 6) begin n_bad++; $display("FAIL rmid_res%0d: data=%0d, required 6", i, got[i]); end
    end
  endtask

  task automatic test_k_zero();
    start_job(0);
    n_cmp++;
    if (res_valid !== 1'b1 || busy !== 1'b1) begin
      n_bad++; $display("FAIL kz_drain: res_valid=%b busy=%b, required 1 1", res_valid, busy);
    end
    start = 1'b1; k_len = 16'd3;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (res_valid !== 1'b1 || res_data !== 24'd0 || res_last !== 1'b0) begin
      n_bad++; $display("FAIL kz_ignore: rv=%b data=%0d last=%b, required 1 0 0", res_valid, res_data, res_last);
    end
    drain(-1, 0);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (got[i] !== 0) begin n_bad++; $display("FAIL kz_res%0d: data=%0d, required 0", i, got[i]); end
    end
    n_cmp++;
    if (done_n1 !== 1'b1 || done_n2 !== 1'b0 || drain_timeout) begin
      n_bad++; $display("FAIL kz_done: pulse=%b,%b timeout=%b, required 1,0,0", done_n1, done_n2, drain_timeout);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_bad++; $display("FAIL kz_idle: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  initial begin
    rst = 1'b0;
    in_left_data = '0; in_left_valid = 1'b0;
    in_up_data = '0; in_up_valid = '0;
    start = 1'b0; k_len = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_forwarding();
    test_basic();
    test_no_overflow();
    test_saturation();
    test_stall();
    test_reset_mid();
    test_k_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_pe_row.md
SYSTOLIC_PE_ROW -- requirements
Module: systolic_pe_row

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width.
REQ-002 SHALL have parameter ACC_W, default 24, accumulator/result width; ACC_W >= 2*DATA_W.
REQ-003 SHALL have parameter NUM_PE, default 4, processing elements in the row.
REQ-004 SHALL have parameter SIGNED_MODE, default 1; 1 = two's-complement operands, 0 = unsigned.
REQ-005 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_left_data  in  DATA_W  left operand into PE0.
- in_left_valid  in  1  in_left_data qualifier.
- in_up_data  in  NUM_PE*DATA_W  top operand per PE; PE i uses slice i.
- in_up_valid  in  NUM_PE  top operand qualifier per PE.
- out_right_data  out  DATA_W  left operand forwarded out of PE NUM_PE-1.
- out_right_valid  out  1  out_right_data qualifier.
- out_down_data  out  NUM_PE*DATA_W  top operands forwarded downward.
- out_down_valid  out  NUM_PE  out_down_data qualifiers.
- start  in  1  one-cycle job start pulse.
- k_len  in  16  MACs per PE for this job; sampled on accepted start.
- busy  out  1  high outside IDLE.
- res_data  out  ACC_W  drained accumulator value.
- res_valid  out  1  res_data valid.
- res_ready  in  1  consumer accepts res_data.
- res_last  out  1  marks the PE NUM_PE-1 result.
- sat  out  1  sticky: some accumulator saturated this job.
- done  out  1  one-cycle pulse after last result handshake.

Function
REQ-006 Left operand and valid SHALL move one PE per cycle: PE i registers PE i-1's left pair (PE0 registers in_left); out_right is PE NUM_PE-1's register.
REQ-007 Each PE SHALL register its up operand and valid into out_down slice i with 1-cycle latency; forwarding SHALL run in every state.
REQ-008 PE i SHALL MAC when its registered left valid and in_up_valid[i] are both high in COMPUTE and its count < k_len; the accumulator updates on that edge.
REQ-009 Product SHALL be 2*DATA_W bits, sign-extended (SIGNED_MODE=1) or zero-extended to ACC_W before addition.
REQ-010 A sum overflowing ACC_W SHALL clamp to the representable max/min for the mode and set sat; sat clears only on accepted start or reset.
REQ-011 FSM states SHALL be IDLE, COMPUTE, DRAIN.
REQ-012 IDLE: start SHALL clear all accumulators, MAC counts and sat, latch k_len, enter COMPUTE; k_len=0 enters DRAIN directly.
REQ-013 COMPUTE -> DRAIN the cycle after every PE's count equals k_len.
REQ-014 DRAIN SHALL present accumulators PE0 first through PE NUM_PE-1 on res_data with res_valid high; index advances only on res_valid&&res_ready; res_data stable while stalled.
REQ-015 res_last SHALL be high with the PE NUM_PE-1 result; its handshake returns FSM to IDLE and pulses done the next cycle.
REQ-016 start outside IDLE SHALL be ignored.
REQ-017 Valid operands beyond k_len, or outside COMPUTE, SHALL be forwarded but not accumulated.

Reset
REQ-018 rst low SHALL immediately force IDLE and zero all forwarding registers, valids, accumulators, counts, res_valid, res_last, sat, done, busy, including mid-COMPUTE or mid-DRAIN.
REQ-019 First accepted start SHALL be the first cycle after rst deasserts.

Structure
REQ-020 FSM state encoding and default-parameter constants SHALL reside in shared package systolic_pkg.
REQ-021 Per-PE forwarding, MAC, saturation and counting SHALL be one sub-module systolic_pe, instantiated NUM_PE times by generate.

Verification
REQ-022 Defaults, SIGNED_MODE=1, k_len=2, PE i fed up (i+1,i+1), left skewed (3,-2) -> results 3*(i+1)-2*(i+1) = 1,2,3,4, res_last with 4, done one cycle later.
REQ-023 k_len=1, left 127 and all up 127 at PE0 (skewed) -> each result 16129, sat=0.
REQ-024 ACC_W=16, k_len=3, all operands -128 (16384 each) -> accumulators clamp at 32767, sat=1.
REQ-025 res_ready low 5 cycles during PE1 drain -> res_data unchanged, no index advance, no duplicate/missing results.
REQ-026 rst low mid-COMPUTE after one MAC -> all outputs 0, busy=0; new start k_len=1 with 2*3 yields 6 per PE.
REQ-027 start k_len=0 -> four zero results, start during DRAIN ignored, done once.
